// File: rtl/leaf_quad_upstream_arbiter_if.sv
// leaf_quad_upstream_arbiter_if: leaf-side and upstream BFT signals of one leaf quad
interface leaf_quad_upstream_arbiter_if #(
    parameter int PACKET_W = 49
);
    logic [PACKET_W-1:0] din_leaf_interface2bft_0;
    logic [PACKET_W-1:0] din_leaf_interface2bft_1;
    logic [PACKET_W-1:0] din_leaf_interface2bft_2;
    logic [PACKET_W-1:0] din_leaf_interface2bft_3;
    logic                stall_0;
    logic                stall_1;
    logic                stall_2;
    logic                stall_3;
    logic [3:0]          overflow;
    logic [PACKET_W-1:0] dout_leaf_interface2bft;
    logic                bft_ready;
    logic [1:0]          grant_idx;

    modport master (
        output din_leaf_interface2bft_0, din_leaf_interface2bft_1,
               din_leaf_interface2bft_2, din_leaf_interface2bft_3, bft_ready,
        input  stall_0, stall_1, stall_2, stall_3, overflow,
               dout_leaf_interface2bft, grant_idx
    );

    modport slave (
        input  din_leaf_interface2bft_0, din_leaf_interface2bft_1,
               din_leaf_interface2bft_2, din_leaf_interface2bft_3, bft_ready,
        output stall_0, stall_1, stall_2, stall_3, overflow,
               dout_leaf_interface2bft, grant_idx
    );
endinterface

// File: rtl/leaf_quad_upstream_arbiter.sv
// leaf_quad_upstream_arbiter: four per-leaf FIFOs drained round-robin into one registered upstream slot
module leaf_quad_upstream_arbiter #(
    parameter int PACKET_W     = 49,
    parameter int FIFO_DEPTH   = 4,
    parameter int STALL_MARGIN = 2
) (
    input logic clk_400,
    input logic reset_400,
    leaf_quad_upstream_arbiter_if.slave bus
);
    localparam int PW = PACKET_W - 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] STALL_AT = CW'(FIFO_DEPTH - STALL_MARGIN);

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t              state, state_nxt;
    logic [PACKET_W-1:0] din [4];
    logic [PW-1:0]       mem [4][FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr [4];
    logic [AW-1:0]       rd_ptr [4];
    logic [CW-1:0]       count [4];
    logic [CW-1:0]       count_nxt [4];
    logic [3:0]          ne, accept, pop, stall_q, overflow_q;
    logic [1:0]          rr_last, winner, grant;
    logic [PW-1:0]       payload;
    logic                load;

    assign din[0] = bus.din_leaf_interface2bft_0;
    assign din[1] = bus.din_leaf_interface2bft_1;
    assign din[2] = bus.din_leaf_interface2bft_2;
    assign din[3] = bus.din_leaf_interface2bft_3;

    always_comb begin
        ne = '0;
        for (int k = 0; k < 4; k++) ne[k] = |count[k];
    end

    // Scan farthest offset first so the nearest non-empty leaf after rr_last wins.
    always_comb begin
        winner = rr_last;
        for (int i = 4; i >= 1; i--)
            if (ne[rr_last + 2'(i)]) winner = rr_last + 2'(i);
        load = (state == EMPTY || bus.bft_ready) && |ne;
        pop  = load ? 4'b0001 << winner : 4'b0000;
    end

    always_comb begin
        state_nxt = state;
        if (state == EMPTY || bus.bft_ready) state_nxt = |ne ? HOLD : EMPTY;
    end

    // A full FIFO still accepts when it is popped in the same cycle.
    always_comb begin
        accept = '0;
        for (int k = 0; k < 4; k++) begin
            accept[k]    = din[k][PW] && (count[k] != FULL || pop[k]);
            count_nxt[k] = count[k] + CW'(accept[k]) - CW'(pop[k]);
        end
    end

    always_ff @(posedge clk_400 or posedge reset_400) begin
        if (reset_400) begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
            stall_q    <= '0;
            overflow_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
                if (pop[k]) rd_ptr[k] <= rd_ptr[k] + 1'b1;
                count[k]   <= count_nxt[k];
                stall_q[k] <= count_nxt[k] >= STALL_AT;
                if (din[k][PW] && !accept[k]) overflow_q[k] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_400) begin
        for (int k = 0; k < 4; k++)
            if (accept[k]) mem[k][wr_ptr[k]] <= din[k][PW-1:0];
    end

    always_ff @(posedge clk_400 or posedge reset_400) begin
        if (reset_400) begin
            state   <= EMPTY;
            payload <= '0;
            grant   <= '0;
            rr_last <= 2'd3;
        end else begin
            state <= state_nxt;
            if (load) begin
                payload <= mem[winner][rd_ptr[winner]];
                grant   <= winner;
                rr_last <= winner;
            end
        end
    end

    assign bus.dout_leaf_interface2bft = state == HOLD ? {1'b1, payload} : '0;
    assign bus.grant_idx = grant;
    assign bus.overflow  = overflow_q;
    assign bus.stall_0   = stall_q[0];
    assign bus.stall_1   = stall_q[1];
    assign bus.stall_2   = stall_q[2];
    assign bus.stall_3   = stall_q[3];
endmodule

// File: tb/tb_leaf_quad_upstream_arbiter.sv
// tb_leaf_quad_upstream_arbiter: directed stimulus with a scoreboard of {grant_idx, payload} per upstream transfer
module tb_leaf_quad_upstream_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [49:0] exp_q [$];

    always #5 clk = ~clk;

    leaf_quad_upstream_arbiter_if #(.PACKET_W(49)) bus ();

    leaf_quad_upstream_arbiter #(.PACKET_W(49), .FIFO_DEPTH(4), .STALL_MARGIN(2)) dut (
        .clk_400(clk),
        .reset_400(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Transfers happen at the next posedge when a valid packet meets bft_ready.
    always @(negedge clk) begin
        if (!rst && bus.dout_leaf_interface2bft[48] && bus.bft_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_packet actual=%0h", {bus.grant_idx, bus.dout_leaf_interface2bft[47:0]});
            end else begin
                chk("packet", {14'd0, bus.grant_idx, bus.dout_leaf_interface2bft[47:0]}, {14'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_din(input int k, input logic [48:0] v);
        case (k)
            0: bus.din_leaf_interface2bft_0 = v;
            1: bus.din_leaf_interface2bft_1 = v;
            2: bus.din_leaf_interface2bft_2 = v;
            default: bus.din_leaf_interface2bft_3 = v;
        endcase
    endtask

    task automatic clear_din();
        for (int k = 0; k < 4; k++) set_din(k, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_din();
        bus.bft_ready = 1'b0;
        exp_q.delete();
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        repeat (3) step();
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_din();
        bus.bft_ready = 1'b0;
        // 1: reset values and single packet latency
        do_reset();
        chk("rst_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        chk("rst_grant", 64'(bus.grant_idx), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        chk("rst_stall", 64'({bus.stall_3, bus.stall_2, bus.stall_1, bus.stall_0}), 64'd0);
        bus.bft_ready = 1'b1;
        set_din(2, {1'b1, 48'hA5});
        exp_q.push_back({2'd2, 48'hA5});
        step();
        clear_din();
        chk("t1_early", 64'(bus.dout_leaf_interface2bft), 64'd0);
        step();
        chk("t1_dout", 64'(bus.dout_leaf_interface2bft), {15'd0, 1'b1, 48'hA5});
        chk("t1_grant", 64'(bus.grant_idx), 64'd2);
        step();
        chk("t1_after", 64'(bus.dout_leaf_interface2bft), 64'd0);
        drain(5);
        // 2: round-robin across four loaded leaves
        do_reset();
        bus.bft_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                set_din(k, {1'b1, 48'(k * 16 + r)});
                exp_q.push_back({2'(k), 48'(k * 16 + r)});
            end
            step();
        end
        clear_din();
        drain(40);
        // 3: backpressure with stall
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_din(1, {1'b1, 48'h300 + 48'(i)});
            exp_q.push_back({2'd1, 48'h300 + 48'(i)});
            step();
            chk("t3_stall1", 64'(bus.stall_1), 64'(i >= 2));
        end
        clear_din();
        for (int i = 0; i < 6; i++) begin
            chk("t3_hold", 64'(bus.dout_leaf_interface2bft), {15'd0, 1'b1, 48'h300});
            chk("t3_hold_grant", 64'(bus.grant_idx), 64'd1);
            step();
        end
        bus.bft_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_consecutive", 64'(bus.dout_leaf_interface2bft[48]), 64'd1);
        end
        drain(10);
        // 4: overflow on leaf 3
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_din(3, {1'b1, 48'h400 + 48'(i)});
            if (i < 5) exp_q.push_back({2'd3, 48'h400 + 48'(i)});
            step();
        end
        clear_din();
        chk("t4_overflow", 64'(bus.overflow), 64'h8);
        bus.bft_ready = 1'b1;
        drain(20);
        chk("t4_overflow_sticky", 64'(bus.overflow), 64'h8);
        // 5: full FIFO pushed and popped together
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_din(0, {1'b1, 48'h500 + 48'(i)});
            exp_q.push_back({2'd0, 48'h500 + 48'(i)});
            step();
        end
        chk("t5_stall0", 64'(bus.stall_0), 64'd1);
        set_din(0, {1'b1, 48'h505});
        exp_q.push_back({2'd0, 48'h505});
        bus.bft_ready = 1'b1;
        step();
        clear_din();
        chk("t5_overflow", 64'(bus.overflow), 64'd0);
        drain(20);
        // 6: asynchronous reset while holding
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_din(1, {1'b1, 48'h610 + 48'(i)});
            set_din(2, {1'b1, 48'h620 + 48'(i)});
            step();
        end
        clear_din();
        step();
        chk("t6_pre_hold", 64'(bus.dout_leaf_interface2bft[48]), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        chk("t6_async_stall", 64'({bus.stall_3, bus.stall_2, bus.stall_1, bus.stall_0}), 64'd0);
        step();
        rst = 1'b0;
        bus.bft_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_empty", 64'(bus.dout_leaf_interface2bft), 64'd0);
        end
        set_din(2, {1'b1, 48'h601});
        set_din(0, {1'b1, 48'h600});
        exp_q.push_back({2'd0, 48'h600});
        exp_q.push_back({2'd2, 48'h601});
        step();
        clear_din();
        drain(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/leaf_quad_upstream_arbiter.md
Name: leaf_quad_upstream_arbiter

Overview:
- Merges the four leaf-to-BFT packet streams of one leaf quad onto a single 49-bit upstream BFT port.
- Each leaf has its own input FIFO. A round-robin arbiter picks which FIFO drains into a registered output slot. Upstream flow control uses bft_ready.
- Sits between the leaf_quad outputs and the BFT switch leaf port, in the 400 MHz domain.

Parameters:
- PACKET_W, 49, packet width. Bit 48 is valid; bits 47:0 are payload.
- FIFO_DEPTH, 4, entries per input FIFO. Must be a power of two and at least 4.
- STALL_MARGIN, 2, free-entry threshold at which stall_k asserts.

Ports:
- clk_400  in  1  sole clock; all logic is on its rising edge.
- reset_400  in  1  asynchronous, active-high reset.
- din_leaf_interface2bft_k (k=0..3)  in  PACKET_W  packet from leaf k; bit 48 = valid.
- stall_k (k=0..3)  out  1  registered; tells leaf k to hold off sending.
- overflow  out  4  sticky per-leaf drop flags; bit k belongs to leaf k.
- dout_leaf_interface2bft  out  PACKET_W  merged upstream packet; bit 48 = valid.
- bft_ready  in  1  upstream accepts the packet on dout this cycle.
- grant_idx  out  2  index of the leaf whose packet occupies the output slot.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All FIFOs empty.
  - dout = 0, grant_idx = 0, stall_k = 0, overflow = 0.
  - Round-robin pointer rr_last = 3, so leaf 0 has first priority.
- Push:
  - A push to FIFO k happens when din_k[48] = 1.
  - It is accepted if count_k < FIFO_DEPTH, or if FIFO k is popped in the same cycle.
  - Otherwise the packet is dropped and overflow[k] is set. overflow[k] clears only on reset.
- FIFO entry format: stores bits 47:0 only. Valid is regenerated on output.
- stall_k: registered; equals 1 when the next-cycle count_k >= FIFO_DEPTH - STALL_MARGIN.
- Output slot, two states:
  - EMPTY: dout = 0.
  - HOLD: dout = {1'b1, payload}.
  - A transfer occurs when state is HOLD and bft_ready = 1 at the clock edge.
  - The slot may load when state is EMPTY or a transfer occurs.
  - On load: if any FIFO is non-empty, pop the winner, go to HOLD, set grant_idx to the winner and set rr_last to the winner.
  - If the slot may load but all FIFOs are empty, go to EMPTY. grant_idx holds its value.
  - In HOLD without bft_ready, dout and grant_idx stay stable. No FIFO pops.
- Arbitration: round-robin. Search order is rr_last+1, rr_last+2, ... modulo 4. The first non-empty FIFO wins.
  - Only current FIFO contents are eligible. A same-cycle din does not bypass its FIFO.
- Latency:
  - din_k valid at edge t into an empty system gives dout valid after edge t+1.
  - With bft_ready held high, throughput is one packet per cycle.
- Simultaneous push and pop on a full FIFO: both happen, count is unchanged, no overflow.
- Simultaneous push and pop on an empty FIFO: impossible, because a pop needs a non-empty FIFO.
- Reset mid-HOLD: the packet in the slot and all FIFO contents are discarded. dout drops to 0 immediately (asynchronous).
- Ordering: per-leaf order is preserved. No ordering is guaranteed across leaves.

Test Plan:
1. Single packet, bft_ready = 1:
   - Stimulus: reset, then din_2 = {1, 48'hA5} for one cycle.
   - Required: dout = {1, 48'hA5} with grant_idx = 2 exactly one cycle after capture. Next cycle dout = 0.
2. Round-robin fairness:
   - Stimulus: all four leaves push 3 packets each in the same cycles, bft_ready = 1.
   - Required: grant_idx output order is 0,1,2,3,0,1,2,3,0,1,2,3 and each leaf's payloads leave in their own order.
3. Backpressure:
   - Stimulus: hold bft_ready = 0 for 10 cycles while leaf 1 pushes 4 packets.
   - Required for the first packet: dout holds leaf 1's first packet, stable.
   - Required for stall_1: asserts once the next-cycle count reaches 2.
   - Required after release: all 4 packets emerge in order on consecutive cycles.
4. Overflow:
   - Stimulus: bft_ready = 0; leaf 3 pushes 6 packets (FIFO_DEPTH = 4, slot holds 1).
   - Required: overflow = 4'b1000. After bft_ready = 1, exactly 5 packets emerge (1 in the slot plus 4 in the FIFO); the 6th is dropped.
5. Full FIFO push with pop:
   - Stimulus: FIFO 0 full, slot in HOLD; bft_ready = 1 and din_0 valid in the same cycle.
   - Required: no overflow and the count stays 4.
6. Reset mid-operation:
   - Stimulus: assert reset_400 between clock edges while in HOLD with FIFOs non-empty.
   - Required: dout = 0 immediately and all FIFOs empty. After release, leaf 0 has first priority.
